// File: rtl/if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_pkg : opcode constants and the fetch-queue entry layout                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package if_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pcnext;
    logic        pred;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry first-word-fall-through queue of fetch entries    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEPTH);

  fetch_entry_t        r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign valid = (r_count != '0);
  assign full  = (r_count == c_cnt_max);
  assign count = r_count;
  assign head  = valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_fetch_queue : PC, ROM fetch and decoupling queue for the decode stage.  |
// | Optional static branch prediction with macro IF_STATIC_PRED_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        redirect,
  input  logic [31:0]                 redirect_pc,
  input  logic                        halt,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [31:0]                 rom_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_pc,
  output logic [31:0]                 out_ir,
  output logic [31:0]                 out_pcnext,
  output logic                        out_pred_taken,
  output logic                        halted,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  logic [31:0]  r_pc;
  logic         r_halted;
  logic [31:0]  w_pc_seq;
  logic [31:0]  w_pc_next;
  logic         w_pred;
  logic         w_pop;
  logic         w_fetch;
  logic         w_full;
  fetch_entry_t w_push_data;
  fetch_entry_t w_head;

  assign rom_addr = r_pc[ADDR_W+1:2];
  assign w_pc_seq = r_pc + 32'd4;
  assign w_pop    = out_valid & out_ready;
  assign w_fetch  = !r_halted && !redirect && (!w_full || w_pop);

`ifdef IF_STATIC_PRED_EN
  logic [5:0]  w_opcode;
  logic [31:0] w_br_off;

  assign w_opcode = rom_data[31:26];
  assign w_br_off = {{14{rom_data[15]}}, rom_data[15:0], 2'b00};

  // Jumps are always taken; conditional branches only when they point backward.
  always_comb begin
    w_pred    = 1'b0;
    w_pc_next = w_pc_seq;
    if (w_opcode == OP_J || w_opcode == OP_JAL) begin
      w_pred    = 1'b1;
      w_pc_next = {w_pc_seq[31:28], rom_data[25:0], 2'b00};
    end else if ((w_opcode == OP_BEQ || w_opcode == OP_BNE) && rom_data[15]) begin
      w_pred    = 1'b1;
      w_pc_next = w_pc_seq + w_br_off;
    end
  end
`else
  assign w_pred    = 1'b0;
  assign w_pc_next = w_pc_seq;
`endif

  assign w_push_data = '{pc: r_pc, ir: rom_data, pcnext: w_pc_seq, pred: w_pred};

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      if (redirect)     r_pc <= redirect_pc & ~32'h3;
      else if (w_fetch) r_pc <= w_pc_next;
      if (halt) r_halted <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear     (clear),
    .flush     (redirect),
    .push      (w_fetch),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .valid     (out_valid),
    .full      (w_full),
    .count     (count)
  );

  assign out_pc         = w_head.pc;
  assign out_ir         = w_head.ir;
  assign out_pcnext     = w_head.pcnext;
  assign out_pred_taken = w_head.pred;
  assign halted         = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_if_fetch_queue : directed table, corner sequences and random vs model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
`ifdef IF_STATIC_PRED_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clear;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_ir;
  logic [31:0]       out_pcnext;
  logic              out_pred_taken;
  logic              halted;
  logic [2:0]        count;

  logic [31:0] rom_mem [1024];

  always #5 clk = ~clk;
  assign rom_data = rom_mem[rom_addr];

  if_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .clear          (clear),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ir         (out_ir),
    .out_pcnext     (out_pcnext),
    .out_pred_taken (out_pred_taken),
    .halted         (halted),
    .count          (count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        clr;
    logic        rdy;
    logic        rdr;
    logic [31:0] rpc;
    logic        hlt;
    logic        ev;
    int          ecnt;
    logic [31:0] epc;
    logic [31:0] eir;
    logic [31:0] erom;
    logic        ehalt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a plain queue of entries plus PC and halt flag.
  fetch_entry_t mq[$];
  logic [31:0]  mpc;
  logic         mhalted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rdr, input logic [31:0] rpc, input logic hlt);
    out_ready   = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    halt        = hlt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    mq.delete();
    mpc     = 32'h0;
    mhalted = 1'b0;
  endfunction

  task automatic do_clear();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] ir, output logic taken);
    int off;
    taken = 1'b0;
    next_pc = pc + 32'd4;
    if (PE) begin
      if (ir[31:26] == 6'd2 || ir[31:26] == 6'd3) begin
        taken   = 1'b1;
        next_pc = ((pc + 32'd4) & 32'hF000_0000) | {4'h0, ir[25:0], 2'b00};
      end else if ((ir[31:26] == 6'd4 || ir[31:26] == 6'd5) && ir[15]) begin
        off     = int'($signed(ir[15:0]));
        taken   = 1'b1;
        next_pc = pc + 32'd4 + 32'(off * 4);
      end
    end
  endfunction

  function automatic void model_step(input logic rdy, input logic rdr, input logic [31:0] rpc, input logic hlt);
    logic         pop;
    logic         fetch;
    logic         tk;
    logic [31:0]  ir;
    logic [31:0]  nxt;
    fetch_entry_t e;
    pop   = (mq.size() != 0) && rdy;
    fetch = !mhalted && !rdr && ((mq.size() < DEPTH) || pop);
    ir    = rom_mem[mpc[11:2]];
    nxt   = next_pc(mpc, ir, tk);
    if (rdr) begin
      mq.delete();
      mpc = rpc & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        e.pc = mpc; e.ir = ir; e.pcnext = mpc + 32'd4; e.pred = tk;
        mq.push_back(e);
        mpc = nxt;
      end
    end
    if (hlt) mhalted = 1'b1;
  endfunction

  task automatic model_check(input int cyc);
    fetch_entry_t h;
    logic         ev;
    ev = (mq.size() != 0);
    if (ev) h = mq[0];
    else    h = '0;
    total++;
    if (out_valid !== ev || out_pc !== h.pc || out_ir !== h.ir || out_pcnext !== h.pcnext ||
        out_pred_taken !== h.pred || count !== 3'(mq.size()) || rom_addr !== mpc[11:2] ||
        halted !== mhalted) begin
      bad++;
      $display("FAIL rand cyc%0d: got v=%b pc=%h ir=%h pn=%h pr=%b cnt=%0d ra=%h h=%b, expected v=%b pc=%h ir=%h pn=%h pr=%b cnt=%0d ra=%h h=%b",
               cyc, out_valid, out_pc, out_ir, out_pcnext, out_pred_taken, count, rom_addr, halted,
               ev, h.pc, h.ir, h.pcnext, h.pred, mq.size(), mpc[11:2], mhalted);
    end
  endtask

  function automatic vec_t mk(input logic clr, input logic rdy, input logic rdr, input logic [31:0] rpc,
                              input logic hlt, input logic ev, input int ecnt, input logic [31:0] epc,
                              input logic [31:0] eir, input logic [31:0] erom, input logic ehalt);
    vec_t v;
    v.clr = clr; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
    v.ev = ev; v.ecnt = ecnt; v.epc = epc; v.eir = eir; v.erom = erom; v.ehalt = ehalt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'(i);
    rom_mem[8] = 32'h1400_FFFE;  // BNE offset -2 at 0x20
    rom_mem[9] = 32'h0800_0040;  // J 0x40 at 0x24

    clear = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    chk("rst valid", 32'(out_valid), 32'h0);
    chk("rst count", 32'(count), 32'h0);
    chk("rst pc", out_pc, 32'h0);
    chk("rst ir", out_ir, 32'h0);
    chk("rst pcnext", out_pcnext, 32'h0);
    chk("rst pred", 32'(out_pred_taken), 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst rom_addr", 32'(rom_addr), 32'h0);
    tick();
    clear = 1'b0;
    model_reset();

    //            clr rdy rdr rpc        hlt ev cnt pc        ir        rom       halted
    vecs.push_back(mk(1, 1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h0,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 1, 32'h0,   32'h0,  32'h1,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 1, 32'h4,   32'h1,  32'h2,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 1, 32'h8,   32'h2,  32'h3,  0));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h0,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h0,   32'h0,  32'h1,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 2, 32'h0,   32'h0,  32'h2,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 3, 32'h0,   32'h0,  32'h3,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 4, 32'h0,   32'h0,  32'h4,  0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 4, 32'h0,   32'h0,  32'h4,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 4, 32'h0,   32'h0,  32'h4,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 4, 32'h4,   32'h1,  32'h5,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 4, 32'h8,   32'h2,  32'h6,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 4, 32'hC,   32'h3,  32'h7,  0));
    vecs.push_back(mk(0, 1, 1, 32'h103, 0, 1, 4, 32'h10,  32'h4,  32'h8,  0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h40, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h100, 32'h40, 32'h41, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 2, 32'h100, 32'h40, 32'h42, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 3, 32'h100, 32'h40, 32'h43, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 2, 32'h104, 32'h41, 32'h43, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 1, 32'h108, 32'h42, 32'h43, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h43, 1));
    vecs.push_back(mk(0, 1, 1, 32'h200, 0, 0, 0, 32'h0,   32'h0,  32'h43, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h80, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,  32'h80, 1));

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].clr) do_clear();
      drive(vecs[k].rdy, vecs[k].rdr, vecs[k].rpc, vecs[k].hlt);
      @(negedge clk);
      chk($sformatf("vec%0d valid", k), 32'(out_valid), 32'(vecs[k].ev));
      chk($sformatf("vec%0d count", k), 32'(count), 32'(vecs[k].ecnt));
      chk($sformatf("vec%0d pc", k), out_pc, vecs[k].epc);
      chk($sformatf("vec%0d ir", k), out_ir, vecs[k].eir);
      chk($sformatf("vec%0d pcnext", k), out_pcnext, vecs[k].ev ? vecs[k].epc + 32'd4 : 32'h0);
      chk($sformatf("vec%0d pred", k), 32'(out_pred_taken), 32'h0);
      chk($sformatf("vec%0d rom_addr", k), 32'(rom_addr), vecs[k].erom);
      chk($sformatf("vec%0d halted", k), 32'(halted), 32'(vecs[k].ehalt));
      tick();
    end

    // Clear lifts a sticky halt and fetching resumes from RESET_PC.
    do_clear();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("recover halted", 32'(halted), 32'h0);
    tick();
    @(negedge clk);
    chk("recover valid", 32'(out_valid), 32'h1);
    chk("recover pc", out_pc, 32'h0);
    tick();

    // Asynchronous clear mid-cycle with three entries held.
    do_clear();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick(); tick();
    chk("async pre count", 32'(count), 32'h3);
    #1 clear = 1'b1;
    #1;
    chk("async count", 32'(count), 32'h0);
    chk("async valid", 32'(out_valid), 32'h0);
    chk("async pc", out_pc, 32'h0);
    tick();
    clear = 1'b0;
    model_reset();

    // Static prediction corner: backward BNE then J.
    drive(1'b1, 1'b1, 32'h20, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("pred redirect rom", 32'(rom_addr), 32'h8);
    tick();
    @(negedge clk);
    chk("bne pc", out_pc, 32'h20);
    chk("bne ir", out_ir, 32'h1400_FFFE);
    chk("bne pcnext", out_pcnext, 32'h24);
    chk("bne pred", 32'(out_pred_taken), 32'(PE));
    chk("bne rom", 32'(rom_addr), PE ? 32'h7 : 32'h9);
    tick();
    drive(1'b1, 1'b1, 32'h24, 1'b0);
    @(negedge clk);
    chk("after bne pc", out_pc, PE ? 32'h1C : 32'h24);
    chk("after bne pcnext", out_pcnext, PE ? 32'h20 : 32'h28);
    chk("after bne pred", 32'(out_pred_taken), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("j redirect rom", 32'(rom_addr), 32'h9);
    tick();
    @(negedge clk);
    chk("j pc", out_pc, 32'h24);
    chk("j pred", 32'(out_pred_taken), 32'(PE));
    chk("j rom", 32'(rom_addr), PE ? 32'h40 : 32'hA);
    tick();
    @(negedge clk);
    chk("after j pc", out_pc, PE ? 32'h100 : 32'h28);
    tick();

    // Random traffic over a ROM seeded with control-flow opcodes.
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      int          sel;
      w   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: w[31:26] = 6'h02;
        1: w[31:26] = 6'h03;
        2: w[31:26] = 6'h04;
        3: w[31:26] = 6'h05;
        4: w[31:26] = 6'h23;
        default: w[31:26] = 6'h00;
      endcase
      rom_mem[i] = w;
    end
    for (int c = 0; c < 600; c++) begin
      logic rdy, rdr, hlt;
      logic [31:0] rpc;
      if (c % 150 == 0) do_clear();
      rdy = ($urandom_range(0, 3) != 0) ^ ((c / 40) % 2 == 1);
      rdr = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      hlt = ($urandom_range(0, 79) == 0);
      drive(rdy, rdr, rpc, hlt);
      @(negedge clk);
      model_check(c);
      @(posedge clk);
      model_step(rdy, rdr, rpc, hlt);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. Owns the PC, reads the combinational instruction ROM and buffers fetched {PC, IR, PC+4} entries in a DEPTH-entry first-word-fall-through queue. The decode stage consumes entries with a valid/ready handshake, replacing the old single-register bubble/stall scheme. Redirect (branch/jump resolution) flushes the queue; halt (syscall-halt from writeback) is sticky and stops fetching.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
ADDR_W, 10, ROM word-address width; rom_addr = pc[ADDR_W+1:2]
RESET_PC, 32'h0, PC value loaded on clear

Ports:
clk  in  1  clock; all state updates on posedge
clear  in  1  reset, asynchronous, active-high
redirect  in  1  flush queue, load redirect_pc
redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
halt  in  1  halt request (halt & syscall at writeback); sticky
rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]
rom_data  in  32  combinational ROM read data
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head
out_pc  out  32  head PC
out_ir  out  32  head instruction
out_pcnext  out  32  head PC+4
out_pred_taken  out  1  head was predicted taken (0 if feature off)
halted  out  1  sticky halt state
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (async, clear=1): pc=RESET_PC, count=0, rd/wr pointers=0, halted=0; out_valid=0, out_pc/out_ir/out_pcnext=0, out_pred_taken=0. Clear mid-operation discards all entries immediately.
- pop = out_valid & out_ready. fetch = !halted & !redirect & (count<DEPTH | pop).
- fetch: write {pc, rom_data, pc+4, pred} at wr_ptr; wr_ptr+1 mod DEPTH; pc <= pc+4 (or predicted target, see feature).
- pop: rd_ptr+1 mod DEPTH. count += fetch - pop; simultaneous fetch and pop when full are legal (count stays DEPTH).
- Latency: PC presented on rom_addr in cycle N is visible on out_* from cycle N+1 when the queue was empty. Empty queue gives out_valid=0; out_* then hold 0.
- Output is first-word fall-through: out_* driven combinationally from the head entry.
- redirect=1: at next edge count=0, pointers=0, pc=redirect_pc&~3. No fetch that cycle. A pop in the same cycle is discarded. Redirect has priority over fetch and pop.
- halt=1: halted=1 from next edge. Fetching stops and the queue still drains via pop. Halted is cleared only by clear. Redirect while halted still flushes and loads pc, with no fetch.
- halt and redirect in the same cycle: both take effect.
- pc+4 wraps modulo 2^32. rom_addr aliases above ADDR_W bits.

Optional Feature:
Macro IF_STATIC_PRED_EN. When defined, the fetched IR is decoded:
- J/JAL (opcode 2/3): pred=1, pc <= {pc+4[31:28], ir[25:0], 2'b00}.
- BEQ/BNE (opcode 4/5) with ir[15]=1 (backward): pred=1, pc <= pc+4 + (sign-extended ir[15:0] << 2).
- Otherwise pred=0, pc <= pc+4.

out_pcnext always remains sequential pc+4; decode uses it on mispredict. When the macro is undefined, no decode logic is built, pred=0 and out_pred_taken is tied 0.

Decomposition:
- Shared package if_pkg: opcode constants OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04, OP_BNE=6'h05; typedef fetch_entry_t {pc[31:0], ir[31:0], pcnext[31:0], pred}.
- One sub-module: fetch_fifo, a generic DEPTH-entry FWFT queue of fetch_entry_t with push/pop/flush/count. if_fetch_queue holds the PC register, fetch control and prediction logic.

Test Plan:
- clear, then release; ROM returns word index in every word; out_ready=1 -> from cycle 1, out_pc sequence 0,4,8,... with out_ir=0,1,2,... and out_pcnext=pc+4; count stays 1.
- out_ready=0 for 6 cycles, DEPTH=4 -> count saturates at 4; rom_addr holds 4 (pc=0x10); then out_ready=1 -> pops 0,4,8,0xC, then 0x10 with no gap or duplicate.
- Queue full, redirect=1 with redirect_pc=0x103 and out_ready=1 -> next cycle count=0, out_valid=0, rom_addr=0x40; following cycle out_pc=0x100.
- halt pulse with 3 entries queued -> halted=1, no further fetch, 3 entries drain, then out_valid=0 permanently; a later redirect to 0x200 -> pc=0x200, still no fetch; clear recovers.
- clear asserted asynchronously mid-cycle with count=3 -> out_valid=0 and count=0 immediately, before the next clk edge.
- IF_STATIC_PRED_EN: BNE at 0x20 with offset 0xFFFE -> next fetch at 0x1C with out_pred_taken=1 and out_pcnext=0x24; J 0x40 at 0x24 -> next fetch at 0x100. Macro off -> fetch is sequential and out_pred_taken=0.
